// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller: state encoding,
// output-mux select codes and the default data width.
// Build option: UART_TX_TWO_STOP_EN adds a second stop-bit state.
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Output mux select: which source drives the TX line
    localparam logic [1:0] MUX_START = 2'b00;  // constant 0
    localparam logic [1:0] MUX_STOP  = 2'b01;  // constant 1 (also idle level)
    localparam logic [1:0] MUX_DATA  = 2'b10;  // serializer output
    localparam logic [1:0] MUX_PAR   = 2'b11;  // parity bit

`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`endif

endpackage

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller. Sequences start, data, optional parity and
// stop bits, one bit per clock, and drives the serializer enable, the line
// mux select, a data-load strobe and busy. All outputs are registered and
// decoded from the next state so they line up with the state register.
// Build option: UART_TX_TWO_STOP_EN -> two stop bits, back-to-back
// acceptance moves from STOP to STOP2.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SER_TIMEOUT = DATA_WIDTH + 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic       par_en,
    input  logic       ser_done,
    output logic       ser_en,
    output logic       data_load,
    output logic [1:0] mux_sel,
    output logic       busy,
    output logic       ser_err
);

    localparam int              WD_W    = $clog2(SER_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(SER_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            par_q, par_d;
    logic            ser_en_q, ser_en_d;
    logic            data_load_q, data_load_d;
    logic [1:0]      mux_sel_q, mux_sel_d;
    logic            busy_q, busy_d;
    logic            ser_err_q, ser_err_d;

    // State, watchdog, parity latch and decoded output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wd_q        <= '0;
            par_q       <= 1'b0;
            ser_en_q    <= 1'b0;
            data_load_q <= 1'b0;
            mux_sel_q   <= MUX_STOP;
            busy_q      <= 1'b0;
            ser_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            par_q       <= par_d;
            ser_en_q    <= ser_en_d;
            data_load_q <= data_load_d;
            mux_sel_q   <= mux_sel_d;
            busy_q      <= busy_d;
            ser_err_q   <= ser_err_d;
        end
    end

    // Next-state logic plus output decode from the next state
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        par_d     = par_q;
        ser_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    state_d = ST_START;
                    par_d   = par_en;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                wd_d    = '0;
            end
            ST_DATA: begin
                if (ser_done) begin
                    state_d = par_q ? ST_PARITY : ST_STOP;
                end else if (wd_q == WD_LAST) begin
                    // Serializer never reported its last bit: close the frame
                    state_d   = ST_STOP;
                    ser_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
            end
`ifdef UART_TX_TWO_STOP_EN
            ST_STOP: begin
                state_d = ST_STOP2;
            end
            ST_STOP2: begin
                if (data_valid) begin
                    state_d = ST_START;
                    par_d   = par_en;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`else
            ST_STOP: begin
                if (data_valid) begin
                    state_d = ST_START;
                    par_d   = par_en;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // START is only ever entered on acceptance, so this is a 1-cycle strobe
        data_load_d = (state_d == ST_START);
        ser_en_d    = (state_d == ST_DATA);
        busy_d      = (state_d != ST_IDLE);

        case (state_d)
            ST_START:  mux_sel_d = MUX_START;
            ST_DATA:   mux_sel_d = MUX_DATA;
            ST_PARITY: mux_sel_d = MUX_PAR;
            default:   mux_sel_d = MUX_STOP;
        endcase
    end

    assign ser_en    = ser_en_q;
    assign data_load = data_load_q;
    assign mux_sel   = mux_sel_q;
    assign busy      = busy_q;
    assign ser_err   = ser_err_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: random frames (parity, serializer
// completion point, back-to-back chaining) compared against a frame-level
// model built from the bit sequence a UART frame should produce.
module tb_uart_tx_fsm;

    localparam int DW     = 8;
    localparam int TO     = DW + 2;
    localparam int NFRAME = 40;
    localparam logic [5:0] V_IDLE = 6'b0000_01;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_valid;
    logic       par_en;
    logic       ser_done;
    logic       ser_en;
    logic       data_load;
    logic [1:0] mux_sel;
    logic       busy;
    logic       ser_err;

    int total = 0;
    int bad   = 0;

    // Expected output vector per frame cycle, and DATA bit number (0 = not data)
    logic [5:0] exp_q[$];
    int         dix_q[$];

    uart_tx_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .par_en     (par_en),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .data_load  (data_load),
        .mux_sel    (mux_sel),
        .busy       (busy),
        .ser_err    (ser_err)
    );

    always #5 clk = ~clk;

    // Packed view: {busy, ser_en, data_load, ser_err, mux_sel}
    function automatic logic [5:0] vec(bit b, bit en, bit ld, bit er, logic [1:0] m);
        return {b, en, ld, er, m};
    endfunction

    task automatic check(input string tag, input logic [5:0] e);
        logic [5:0] o;
        o = {busy, ser_en, data_load, ser_err, mux_sel};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Frame model: start bit, data bits until ser_done (or timeout limit),
    // parity bit if requested and no timeout, then the stop bit(s)
    task automatic build(input bit p, input int k);
        int  n;
        bit  tmo;
        tmo = (k > TO);
        n   = tmo ? TO : k;
        exp_q.delete();
        dix_q.delete();
        exp_q.push_back(vec(1, 0, 1, 0, 2'b00)); dix_q.push_back(0);
        for (int d = 1; d <= n; d++) begin
            exp_q.push_back(vec(1, 1, 0, 0, 2'b10)); dix_q.push_back(d);
        end
        if (p && !tmo) begin
            exp_q.push_back(vec(1, 0, 0, 0, 2'b11)); dix_q.push_back(0);
        end
        exp_q.push_back(vec(1, 0, 0, tmo, 2'b01)); dix_q.push_back(0);
`ifdef UART_TX_TWO_STOP_EN
        exp_q.push_back(vec(1, 0, 0, 0, 2'b01)); dix_q.push_back(0);
`endif
    endtask

    // Called just after the acceptance edge; ends just after the edge that
    // leaves the last stop bit (next frame accepted if next_valid)
    task automatic run_frame(input int f, input bit p, input int k,
                             input bit next_valid, input bit next_par);
        int sz;
        build(p, k);
        sz = exp_q.size();
        $display("frame %0d: par=%0d done_at=%0d b2b=%0d len=%0d", f, p, k, next_valid, sz);
        check($sformatf("f%0d c0", f), exp_q[0]);
        for (int j = 0; j < sz; j++) begin
            @(negedge clk);
            ser_done = (dix_q[j] != 0) ? (dix_q[j] == k) : 1'($urandom_range(0, 1));
            if (j == sz - 1) begin
                data_valid = next_valid;
                par_en     = next_par;
            end else begin
                data_valid = 1'($urandom_range(0, 1));
                par_en     = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (j < sz - 1)
                check($sformatf("f%0d c%0d", f, j + 1), exp_q[j + 1]);
            else if (!next_valid)
                check($sformatf("f%0d idle", f), V_IDLE);
        end
    endtask

    bit p_a  [NFRAME];
    int k_a  [NFRAME];
    bit nv_a [NFRAME];

    initial begin
        bit chained;
        rst = 1'b1; data_valid = 1'b0; par_en = 1'b0; ser_done = 1'b0;
        #1;
        check("reset", V_IDLE);
        @(negedge clk);
        rst = 1'b0;

        // Frame plan: directed corners first, random afterwards
        for (int f = 0; f < NFRAME; f++) begin
            p_a[f]  = 1'($urandom_range(0, 1));
            k_a[f]  = $urandom_range(1, TO + 3);
            nv_a[f] = ($urandom_range(0, 2) == 0);
        end
        p_a[0] = 0; k_a[0] = DW;     nv_a[0] = 0;  // 8N1
        p_a[1] = 1; k_a[1] = DW;     nv_a[1] = 0;  // parity
        p_a[2] = 1; k_a[2] = TO + 1; nv_a[2] = 0;  // watchdog timeout
        p_a[3] = 0; k_a[3] = TO;     nv_a[3] = 0;  // ser_done on last allowed cycle
        nv_a[4] = 1; nv_a[5] = 1;                  // back-to-back chain
        nv_a[NFRAME-1] = 0;

        chained = 0;
        for (int f = 0; f < NFRAME; f++) begin
            if (!chained) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    @(negedge clk);
                    data_valid = 1'b0;
                    ser_done   = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    check($sformatf("gap%0d", f), V_IDLE);
                end
                @(negedge clk);
                data_valid = 1'b1;
                par_en     = p_a[f];
                ser_done   = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            run_frame(f, p_a[f], k_a[f], nv_a[f],
                      (f < NFRAME - 1) ? p_a[(f + 1) % NFRAME] : 1'b0);
            chained = nv_a[f];
        end

        // Asynchronous reset in the middle of DATA
        @(negedge clk);
        data_valid = 1'b1; par_en = 1'b1; ser_done = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst data", vec(1, 1, 0, 0, 2'b10));
        #2 rst = 1'b1;
        #1;
        check("rst_mid", V_IDLE);
        @(posedge clk); #1;
        check("rst_hold", V_IDLE);
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-frame applied and released");

        // Clean frame after reset
        @(negedge clk);
        data_valid = 1'b1; par_en = 1'b0;
        @(posedge clk); #1;
        run_frame(NFRAME, 1'b0, DW, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
